// File: rtl/reg_file_sb_if.sv
// Issue/writeback bus of the scoreboarded register file.
// The master side is the pipeline (decode/issue plus writeback); the slave side is reg_file_sb.
interface reg_file_sb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] d_in;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0] r1;
  logic [DATA_WIDTH-1:0] r2;
  logic                  alloc_en;
  logic [ADDR_WIDTH-1:0] alloc_rd;
  logic                  busy1;
  logic                  busy2;
  logic                  ready;

  modport master (
    output wr_en, rd, d_in, rs1, rs2, alloc_en, alloc_rd,
    input  r1, r2, busy1, busy2, ready
  );

  modport slave (
    input  wr_en, rd, d_in, rs1, rs2, alloc_en, alloc_rd,
    output r1, r2, busy1, busy2, ready
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file with a post-reset clear engine and a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_sb #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  wr_fire;
  logic                  alloc_fire;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] r1_c, r2_c;
  logic                  busy1_c, busy2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clear_cnt_q <= ADDR_WIDTH'(1);
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  // The clear engine walks registers 1..DEPTH-1, one per edge, then hands over to READY.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == CLEAR) begin
      clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
      if (clear_cnt_q == '1) begin
        state_d = READY;
      end
    end
  end

  always_comb begin
    ready      = (state_q == READY);
    wr_fire    = ready && bus.wr_en && (bus.rd != '0);
    alloc_fire = ready && bus.alloc_en && (bus.alloc_rd != '0);
    mem_we     = (state_q == CLEAR) || wr_fire;
    mem_addr   = (state_q == CLEAR) ? clear_cnt_q : bus.rd;
    mem_data   = (state_q == CLEAR) ? RESET_VAL : bus.d_in;
  end

  // The set is applied after the clear, so a same-cycle reallocation keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) begin
      busy_d[bus.rd] = 1'b0;
    end
    if (alloc_fire) begin
      busy_d[bus.alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Storage has no reset so it can map onto RAM; the clear engine initialises it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_comb begin
    r1_c    = '0;
    r2_c    = '0;
    busy1_c = 1'b0;
    busy2_c = 1'b0;
    if (ready && (bus.rs1 != '0)) begin
      r1_c    = mem[bus.rs1];
      busy1_c = busy_q[bus.rs1];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (bus.rd == bus.rs1)) begin
        r1_c    = bus.d_in;
        busy1_c = alloc_fire && (bus.alloc_rd == bus.rs1);
      end
`endif
    end
    if (ready && (bus.rs2 != '0)) begin
      r2_c    = mem[bus.rs2];
      busy2_c = busy_q[bus.rs2];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (bus.rd == bus.rs2)) begin
        r2_c    = bus.d_in;
        busy2_c = alloc_fire && (bus.alloc_rd == bus.rs2);
      end
`endif
    end
  end

  assign bus.r1    = r1_c;
  assign bus.r2    = r2_c;
  assign bus.busy1 = busy1_c;
  assign bus.busy2 = busy2_c;
  assign bus.ready = ready;

endmodule
